inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 159 +++++++++++++++
 tb/tb_inst_fetch.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch unit: a single-outstanding-request memory interface,
// a one-entry output register toward decode and a one-entry skid buffer.
// Branch redirects flush the output/skid and retarget the fetch PC. If the
// request in flight has not returned yet, the redirect waits in DRAIN for it.
// Optional feature: define INST_FETCH_PERF_EN to add the fetch_cnt_o
// counter, which counts instructions loaded into inst_o.
module inst_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [15:0] branch_addr_i,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic        imem_req_o,
  output logic [15:0] imem_addr_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic [15:0] pc_o
`ifdef INST_FETCH_PERF_EN
  ,
  output logic [15:0] fetch_cnt_o
`endif
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, FULL} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   fetch_pc_q, fetch_pc_d;
  logic [DW-1:0]   inst_q, inst_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic            valid_q, valid_d;
  logic [DW-1:0]   skid_data_q, skid_data_d;
  logic [AW-1:0]   skid_pc_q, skid_pc_d;
  logic [AW-1:0]   redir_q, redir_d;
  logic            req_q, req_d;
  logic            load;

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      inst_q      <= '0;
      pc_q        <= '0;
      valid_q     <= 1'b0;
      skid_data_q <= '0;
      skid_pc_q   <= '0;
      redir_q     <= '0;
      req_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      inst_q      <= inst_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      skid_data_q <= skid_data_d;
      skid_pc_q   <= skid_pc_d;
      redir_q     <= redir_d;
      req_q       <= req_d;
    end
  end

  // Next-state, fetch PC, output slot and skid control.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    inst_d      = inst_q;
    pc_d        = pc_q;
    valid_d     = valid_q & stall_i;  // an unstalled valid instruction is consumed
    skid_data_d = skid_data_q;
    skid_pc_d   = skid_pc_q;
    redir_d     = redir_q;
    load        = 1'b0;

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (branch_i) begin
          if (imem_ack_i) begin
            fetch_pc_d = branch_addr_i;
          end else begin
            redir_d = branch_addr_i;
            state_d = DRAIN;
          end
        end else if (imem_ack_i) begin
          if (!valid_q || !stall_i) begin
            inst_d  = imem_data_i;
            pc_d    = fetch_pc_q;
            valid_d = 1'b1;
            load    = 1'b1;
          end else begin
            skid_data_d = imem_data_i;
            skid_pc_d   = fetch_pc_q;
            state_d     = FULL;
          end
          fetch_pc_d = fetch_pc_q + AW'(1);
        end
      end
      DRAIN: begin
        if (imem_ack_i) begin
          fetch_pc_d = branch_i ? branch_addr_i : redir_q;
          state_d    = REQ;
        end else if (branch_i) begin
          redir_d = branch_addr_i;
        end
      end
      FULL: begin
        if (branch_i) begin
          fetch_pc_d = branch_addr_i;
          state_d    = REQ;
        end else if (!stall_i) begin
          inst_d  = skid_data_q;
          pc_d    = skid_pc_q;
          valid_d = 1'b1;
          load    = 1'b1;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    // A redirect flushes the output slot regardless of any load or consume.
    if (branch_i) begin
      valid_d = 1'b0;
    end

    req_d = (state_d == REQ) || (state_d == DRAIN);
  end

  assign imem_req_o   = req_q;
  assign imem_addr_o  = fetch_pc_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;
  assign pc_o         = pc_q;

`ifdef INST_FETCH_PERF_EN
  logic [AW-1:0] cnt_q;

  // Count every instruction placed into the output slot; only reset clears it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= cnt_q + AW'(1);
    end
  end

  assign fetch_cnt_o = cnt_q;
`else
  // No performance counter in this build; the load strobe is only steering logic.
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios followed by random stall, ack,
// branch and reset traffic. A scoreboard of expected program-order PCs is
// rebuilt on every redirect or reset; a negedge monitor checks each
// consumed instruction against it, plus request-hold and flush rules.
module tb_inst_fetch;

  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch;
  logic [15:0] baddr;
  logic        ack;
  logic [31:0] idata;
  logic        req;
  logic [15:0] addr;
  logic [31:0] inst;
  logic        valid;
  logic [15:0] pc;
`ifdef INST_FETCH_PERF_EN
  logic [15:0] fcnt;
`endif

  int total = 0;
  int bad   = 0;
  int n_cons = 0;

  logic [15:0] exp_q[$];
  logic [15:0] exp_tail;

  logic        hold_p = 1'b0;
  logic [15:0] hold_addr = 16'h0;
  logic        br_p = 1'b0;

  inst_fetch #(.RESET_PC(RST_PC)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .stall_i      (stall),
    .branch_i     (branch),
    .branch_addr_i(baddr),
    .imem_ack_i   (ack),
    .imem_data_i  (idata),
    .imem_req_o   (req),
    .imem_addr_o  (addr),
    .inst_o       (inst),
    .inst_valid_o (valid),
    .pc_o         (pc)
`ifdef INST_FETCH_PERF_EN
    ,
    .fetch_cnt_o  (fcnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents are a fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {~a, a ^ 16'h3C5A};
  endfunction

  assign idata = mem_word(addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_tail = exp_tail + 16'd1;
      exp_q.push_back(exp_tail);
    end
  endtask

  // Program order restarts at a redirect target or at the reset PC.
  task automatic q_restart(input logic [15:0] start);
    exp_q.delete();
    exp_q.push_back(start);
    exp_tail = start;
    refill();
  endtask

  // Wait for the next active edge, then apply inputs for the following one.
  task automatic step(input logic st, input logic br, input logic [15:0] ba, input logic ak);
    @(posedge clk);
    #2;
    stall  = st;
    branch = br;
    baddr  = ba;
    ack    = ak;
    if (br && rst) q_restart(ba);
    refill();
  endtask

  // Monitor: consumed instructions, request hold and flush behaviour.
  always @(negedge clk) begin
    if (!rst) begin
      hold_p = 1'b0;
      br_p   = 1'b0;
    end else begin
      if (hold_p) begin
        chk("req_held", 32'(req), 32'd1);
        chk("addr_held", 32'(addr), 32'(hold_addr));
      end
      if (br_p) chk("flush_valid", 32'(valid), 32'd0);
      if (valid && !stall && !branch) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL scoreboard_empty: got pc %h expected none", pc);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          chk("consumed_pc", 32'(pc), 32'(e));
          chk("consumed_inst", inst, mem_word(e));
          n_cons++;
        end
      end
      hold_p    = req && !ack;
      hold_addr = addr;
      br_p      = branch;
    end
  end

  initial begin
    rst = 1'b0; stall = 1'b0; branch = 1'b0; baddr = 16'h0; ack = 1'b0;
    q_restart(RST_PC);
    #1;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_addr", 32'(addr), 32'(RST_PC));
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1; ack = 1'b1;

    // Back-to-back fetch from reset with ack tied high.
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 16'h0, 1'b1);
      chk("b2b_addr", 32'(addr), 32'(k));
      chk("b2b_req", 32'(req), 32'd1);
      if (k >= 1) begin
        chk("b2b_valid", 32'(valid), 32'd1);
        chk("b2b_pc", 32'(pc), 32'(k - 1));
      end
    end
    // Ack at address 5 while stalled: skid fills and requests stop.
    step(1'b1, 1'b0, 16'h0, 1'b1);
    chk("pre_full_addr", 32'(addr), 32'd5);
    step(1'b1, 1'b0, 16'h0, 1'b1);
    chk("full_req", 32'(req), 32'd0);
    chk("full_pc", 32'(pc), 32'd4);
    chk("full_addr", 32'(addr), 32'd6);
    step(1'b1, 1'b0, 16'h0, 1'b1);
    chk("full_req2", 32'(req), 32'd0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    chk("full_req3", 32'(req), 32'd0);
    chk("full_valid", 32'(valid), 32'd1);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("skid_pc", 32'(pc), 32'd5);
    chk("skid_inst", inst, mem_word(16'd5));
    chk("skid_req", 32'(req), 32'd1);
    chk("skid_next_addr", 32'(addr), 32'd6);

    // Branch while request at 7 is pending, ack two cycles later.
    step(1'b0, 1'b1, 16'h0100, 1'b0);
    chk("pend_addr", 32'(addr), 32'd7);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    chk("drain_valid", 32'(valid), 32'd0);
    chk("drain_addr", 32'(addr), 32'd7);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("redir_addr", 32'(addr), 32'h0100);
    chk("redir_valid", 32'(valid), 32'd0);

    // Wrap at 0xFFFF, then branch with ack at 0xFFFF.
    step(1'b0, 1'b1, 16'hFFFF, 1'b1);
    chk("tgt_pc", 32'(pc), 32'h0100);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("at_ffff", 32'(addr), 32'hFFFF);
    step(1'b0, 1'b1, 16'hFFFF, 1'b1);
    chk("wrap_addr", 32'(addr), 32'h0000);
    chk("wrap_pc", 32'(pc), 32'hFFFF);
    step(1'b0, 1'b1, 16'h0200, 1'b1);
    chk("at_ffff2", 32'(addr), 32'hFFFF);
    step(1'b0, 1'b1, 16'h0300, 1'b0);
    chk("br_ack_addr", 32'(addr), 32'h0200);
    chk("br_ack_valid", 32'(valid), 32'd0);

    // Reset in the middle of DRAIN.
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("drain2_addr", 32'(addr), 32'h0200);
    #2;
    rst = 1'b0;
    q_restart(RST_PC);
    #1;
    chk("mid_rst_req", 32'(req), 32'd0);
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_inst", inst, 32'd0);
    chk("mid_rst_pc", 32'(pc), 32'd0);
    chk("mid_rst_addr", 32'(addr), 32'(RST_PC));
`ifdef INST_FETCH_PERF_EN
    chk("mid_rst_cnt", 32'(fcnt), 32'd0);
`endif
    repeat (3) step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("in_rst_valid", 32'(valid), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("post_rst_addr", 32'(addr), 32'(RST_PC));
    chk("post_rst_req", 32'(req), 32'd1);
`ifdef INST_FETCH_PERF_EN
    chk("post_rst_cnt", 32'(fcnt), 32'd0);
`endif
    repeat (4) step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("post_rst_pc", 32'(pc), 32'(RST_PC + 16'd3));
`ifdef INST_FETCH_PERF_EN
    chk("cnt4", 32'(fcnt), 32'd4);
`endif

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) < 3) begin
        @(posedge clk);
        #2;
        rst = 1'b0;
        q_restart(RST_PC);
        repeat ($urandom_range(1, 2)) step(1'($urandom_range(0, 1)), 1'b0, 16'h0, 1'($urandom_range(0, 1)));
        @(posedge clk);
        #2;
        rst = 1'b1;
      end else begin
        logic [15:0] tgt;
        tgt = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 3)) : 16'($urandom);
        step(($urandom_range(0, 9) < 3), ($urandom_range(0, 99) < 4), tgt, ($urandom_range(0, 9) < 6));
      end
    end
    step(1'b0, 1'b0, 16'h0, 1'b0);
    chk("progress", 32'(n_cons > 200), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
